// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, pipeline flag bundle and total-period helper.
package vga_timing_pkg;

  localparam int unsigned VGA640_H_ACT   = 640;
  localparam int unsigned VGA640_H_FRONT = 16;
  localparam int unsigned VGA640_H_SYNC  = 96;
  localparam int unsigned VGA640_H_BACK  = 48;
  localparam int unsigned VGA640_V_ACT   = 480;
  localparam int unsigned VGA640_V_FRONT = 10;
  localparam int unsigned VGA640_V_SYNC  = 2;
  localparam int unsigned VGA640_V_BACK  = 33;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        shown;
    logic [15:0] x;
    logic [15:0] y;
  } vga_flags_t;

  function automatic int unsigned calc_total(int unsigned sync, int unsigned back,
                                             int unsigned act, int unsigned front);
    return sync + back + act + front;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; output is the input delayed by DEPTH enabled cycles.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with FIFO read scheduling so returned pixels land on active positions.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW      = 8,
  parameter int unsigned H_ACT   = VGA640_H_ACT,
  parameter int unsigned H_FRONT = VGA640_H_FRONT,
  parameter int unsigned H_SYNC  = VGA640_H_SYNC,
  parameter int unsigned H_BACK  = VGA640_H_BACK,
  parameter int unsigned V_ACT   = VGA640_V_ACT,
  parameter int unsigned V_FRONT = VGA640_V_FRONT,
  parameter int unsigned V_SYNC  = VGA640_V_SYNC,
  parameter int unsigned V_BACK  = VGA640_V_BACK,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned RD_LEAD = 2,
  parameter int unsigned V_SKIP  = 9
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iEN,
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  output logic          READ_Request,
  output logic [CW-1:0] oVGA_R,
  output logic [CW-1:0] oVGA_G,
  output logic [CW-1:0] oVGA_B,
  output logic          oVGA_H_SYNC,
  output logic          oVGA_V_SYNC,
  output logic          oVGA_BLANK_N,
  output logic          oVGA_CLOCK,
  output logic [15:0]   oX,
  output logic [15:0]   oY,
  output logic          oFrame_Start
);

  localparam int unsigned H_TOT = calc_total(H_SYNC, H_BACK, H_ACT, H_FRONT);
  localparam int unsigned V_TOT = calc_total(V_SYNC, V_BACK, V_ACT, V_FRONT);
  localparam int unsigned H_ST  = H_SYNC + H_BACK;
  localparam int unsigned V_ST  = V_SYNC + V_BACK;

  if (H_TOT > 65535 || V_TOT > 65535) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOT/V_TOT exceed 16-bit counter range");
  end
  if (RD_LEAD < 1 || RD_LEAD > 8) begin : g_bad_lead
    $error("vga_timing_ctrl: RD_LEAD must be 1..8");
  end

  logic [15:0] hc_q, hc_d, vc_q, vc_d;
  logic        rd_q;
  logic        h_act, v_act, skip_ok;
  logic [15:0] v_line;
  vga_flags_t  flags_s0, flags_dl;

  always_comb begin
    hc_d = hc_q + 16'd1;
    vc_d = vc_q;
    if (hc_q == 16'(H_TOT - 1)) begin
      hc_d = '0;
      vc_d = (vc_q == 16'(V_TOT - 1)) ? '0 : vc_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (iEN) begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign v_line = vc_q - 16'(V_ST);

  // A zero skip would make the line compare constant-true.
  if (V_SKIP == 0) begin : g_no_skip
    assign skip_ok = 1'b1;
  end else begin : g_skip
    assign skip_ok = (v_line >= 16'(V_SKIP));
  end

  always_comb begin
    h_act          = (hc_q >= 16'(H_ST)) && (hc_q < 16'(H_ST + H_ACT));
    v_act          = (vc_q >= 16'(V_ST)) && (vc_q < 16'(V_ST + V_ACT));
    flags_s0       = '0;
    flags_s0.hs    = (hc_q < 16'(H_SYNC));
    flags_s0.vs    = (vc_q < 16'(V_SYNC));
    flags_s0.act   = h_act && v_act;
    flags_s0.shown = h_act && v_act && skip_ok;
    if (h_act && v_act) begin
      flags_s0.x = hc_q - 16'(H_ST);
      flags_s0.y = v_line;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_q <= 1'b0;
    end else if (iEN) begin
      rd_q <= flags_s0.shown;
    end
  end

  // A stalled cycle must not consume a FIFO word.
  assign READ_Request = rd_q & iEN;

  vga_delay_line #(
    .WIDTH ($bits(vga_flags_t)),
    .DEPTH (RD_LEAD)
  ) u_delay (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .en_i   (iEN),
    .d_i    (flags_s0),
    .q_o    (flags_dl)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_H_SYNC  <= ~HS_POL;
      oVGA_V_SYNC  <= ~VS_POL;
      oVGA_BLANK_N <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oFrame_Start <= 1'b0;
    end else if (iEN) begin
      oVGA_R       <= flags_dl.shown ? iRed   : '0;
      oVGA_G       <= flags_dl.shown ? iGreen : '0;
      oVGA_B       <= flags_dl.shown ? iBlue  : '0;
      oVGA_H_SYNC  <= flags_dl.hs ~^ HS_POL;
      oVGA_V_SYNC  <= flags_dl.vs ~^ VS_POL;
      oVGA_BLANK_N <= flags_dl.act;
      oX           <= flags_dl.x;
      oY           <= flags_dl.y;
      oFrame_Start <= flags_dl.act && (flags_dl.x == '0) && (flags_dl.y == '0);
    end
  end

  assign oVGA_CLOCK = iCLK;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: three reduced-timing instances (lead 2/1/8, polarity, skip) checked against an arithmetic model.
module tb_vga_timing_ctrl;

  localparam int H_A = 16, H_F = 2, H_S = 3, H_B = 2;
  localparam int V_A = 12, V_F = 1, V_S = 2, V_B = 2;
  localparam int HT  = H_A + H_F + H_S + H_B;
  localparam int VT  = V_A + V_F + V_S + V_B;
  localparam int FR  = HT * VT;

  function automatic int lead_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 8;
  endfunction
  function automatic bit pol_of(int g);
    return (g == 1);
  endfunction
  function automatic int skip_of(int g);
    return (g == 1) ? 0 : 3;
  endfunction

  typedef struct {
    bit         hs, vs, bn, fs, rd;
    logic [7:0] r, gr, b;
    logic [15:0] x, y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en [3];
  logic        rd [3], hs [3], vs [3], bn [3], ck [3], fs [3];
  logic [7:0]  o_r [3], o_g [3], o_b [3];
  logic [15:0] ox [3], oy [3];
  int          n [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Enabled edges since reset release, per instance.
  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) n[g] = 0;
      else if (en[g]) n[g] = n[g] + 1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = lead_of(g);
    logic [7:0] ir, ig, ib;
    int         rq [8];
    int         req_cnt;

    // FIFO model: word for the k-th request is k, delivered L-1 enabled cycles after the request.
    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) rq[i] = -1;
        req_cnt = 0;
        ir = '0; ig = '0; ib = '0;
      end else if (en[g]) begin
        for (int i = 7; i > 0; i--) rq[i] = rq[i-1];
        if (rd[g] === 1'b1) begin
          rq[0]   = req_cnt;
          req_cnt = req_cnt + 1;
        end else begin
          rq[0] = -1;
        end
        if (rq[L-1] >= 0) begin
          ir = 8'(rq[L-1]);
          ig = ~8'(rq[L-1]);
          ib = 8'(rq[L-1]) ^ 8'h5a;
        end else begin
          ir = 8'($urandom); ig = 8'($urandom); ib = 8'($urandom);
        end
      end
    end

    vga_timing_ctrl #(
      .CW(8), .H_ACT(H_A), .H_FRONT(H_F), .H_SYNC(H_S), .H_BACK(H_B),
      .V_ACT(V_A), .V_FRONT(V_F), .V_SYNC(V_S), .V_BACK(V_B),
      .HS_POL(pol_of(g)), .VS_POL(pol_of(g)), .RD_LEAD(L), .V_SKIP(skip_of(g))
    ) u_dut (
      .iCLK         (clk),
      .iRST_N       (rst_n),
      .iEN          (en[g]),
      .iRed         (ir),
      .iGreen       (ig),
      .iBlue        (ib),
      .READ_Request (rd[g]),
      .oVGA_R       (o_r[g]),
      .oVGA_G       (o_g[g]),
      .oVGA_B       (o_b[g]),
      .oVGA_H_SYNC  (hs[g]),
      .oVGA_V_SYNC  (vs[g]),
      .oVGA_BLANK_N (bn[g]),
      .oVGA_CLOCK   (ck[g]),
      .oX           (ox[g]),
      .oY           (oy[g]),
      .oFrame_Start (fs[g])
    );
  end

  function automatic bit shown_at(int g, int p);
    int q, x, y;
    q = p % FR;
    x = (q % HT) - (H_S + H_B);
    y = (q / HT) - (V_S + V_B);
    return x >= 0 && x < H_A && y >= skip_of(g) && y < V_A;
  endfunction

  // Outputs after enabled edge n show the raster position n-lead-1.
  function automatic exp_t model(int g, int nn, bit en_now);
    exp_t e;
    int p, q, hc, vc, x, y, idx;
    bit pol, act;
    pol  = pol_of(g);
    e.hs = !pol; e.vs = !pol; e.bn = 0; e.fs = 0;
    e.r = '0; e.gr = '0; e.b = '0; e.x = '0; e.y = '0;
    p = nn - lead_of(g) - 1;
    if (p >= 0) begin
      q   = p % FR;
      hc  = q % HT;
      vc  = q / HT;
      x   = hc - (H_S + H_B);
      y   = vc - (V_S + V_B);
      act = x >= 0 && x < H_A && y >= 0 && y < V_A;
      e.hs = (hc < H_S) ? pol : !pol;
      e.vs = (vc < V_S) ? pol : !pol;
      e.bn = act;
      if (act) begin
        e.x  = 16'(x);
        e.y  = 16'(y);
        e.fs = (x == 0 && y == 0);
      end
      if (shown_at(g, p)) begin
        idx  = (p / FR) * (V_A - skip_of(g)) * H_A + (y - skip_of(g)) * H_A + x;
        e.r  = 8'(idx);
        e.gr = ~8'(idx);
        e.b  = 8'(idx) ^ 8'h5a;
      end
    end
    e.rd = en_now && (nn >= 1) && shown_at(g, nn - 1);
    return e;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      for (int g = 0; g < 3; g++) begin
        tests++;
        if ({hs[g], vs[g]} !== {2{!pol_of(g)}}) begin
          fails++;
          $display("FAIL reset_sync inst%0d got hs=%b vs=%b exp %b", g, hs[g], vs[g], !pol_of(g));
        end
        tests++;
        if ({bn[g], fs[g], rd[g], o_r[g], o_g[g], o_b[g], ox[g], oy[g]} !== '0) begin
          fails++;
          $display("FAIL reset_zero inst%0d got bn=%b fs=%b rd=%b r=%0h x=%0d y=%0d exp all 0",
                   g, bn[g], fs[g], rd[g], o_r[g], ox[g], oy[g]);
        end
        tests++;
        if (ck[g] !== clk) begin
          fails++;
          $display("FAIL clock_pass inst%0d got %b exp %b", g, ck[g], clk);
        end
      end
    end
  endtask

  task automatic test_stream(int cycles, bit from_reset, bit stall);
    exp_t e;
    int   first_hs [3];
    int   rd_cnt [3];
    for (int g = 0; g < 3; g++) begin
      first_hs[g] = -1;
      rd_cnt[g]   = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (stall) en[0] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        e = model(g, n[g], en[g]);
        if (hs[g] === pol_of(g) && first_hs[g] < 0) first_hs[g] = n[g];
        if (rd[g] === 1'b1 && n[g] >= 1 && n[g] <= FR) rd_cnt[g]++;
        tests++;
        if ({hs[g], vs[g]} !== {e.hs, e.vs}) begin
          fails++;
          $display("FAIL sync inst%0d n=%0d got hs=%b vs=%b exp hs=%b vs=%b",
                   g, n[g], hs[g], vs[g], e.hs, e.vs);
        end
        tests++;
        if ({bn[g], fs[g], rd[g]} !== {e.bn, e.fs, e.rd}) begin
          fails++;
          $display("FAIL ctrl inst%0d n=%0d got bn=%b fs=%b rd=%b exp bn=%b fs=%b rd=%b",
                   g, n[g], bn[g], fs[g], rd[g], e.bn, e.fs, e.rd);
        end
        tests++;
        if ({o_r[g], o_g[g], o_b[g]} !== {e.r, e.gr, e.b}) begin
          fails++;
          $display("FAIL rgb inst%0d n=%0d got %h/%h/%h exp %h/%h/%h",
                   g, n[g], o_r[g], o_g[g], o_b[g], e.r, e.gr, e.b);
        end
        tests++;
        if ({ox[g], oy[g]} !== {e.x, e.y}) begin
          fails++;
          $display("FAIL xy inst%0d n=%0d got x=%0d y=%0d exp x=%0d y=%0d",
                   g, n[g], ox[g], oy[g], e.x, e.y);
        end
      end
    end
    if (from_reset) begin
      for (int g = 0; g < 3; g++) begin
        tests++;
        if (first_hs[g] != lead_of(g) + 1) begin
          fails++;
          $display("FAIL first_hsync inst%0d got edge %0d exp %0d", g, first_hs[g], lead_of(g) + 1);
        end
        tests++;
        if (rd_cnt[g] != (V_A - skip_of(g)) * H_A) begin
          fails++;
          $display("FAIL req_per_frame inst%0d got %0d exp %0d",
                   g, rd_cnt[g], (V_A - skip_of(g)) * H_A);
        end
      end
    end
  endtask

  task automatic test_frame();
    test_stream(2 * FR + 12, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    test_stream(3 * FR, 1'b0, 1'b1);
    en[0] = 1'b1;
  endtask

  task automatic test_midframe_reset();
    int  target;
    bit  found;
    target = 10 * HT + 12;
    found  = 0;
    for (int c = 0; c < 2 * FR && !found; c++) begin
      @(posedge clk);
      if ((n[0] % FR) == target) found = 1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL midframe_wait got no position %0d within %0d cycles exp reached", target, 2 * FR);
    end
    #3;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      tests++;
      if ({hs[g], vs[g], bn[g], fs[g], rd[g], o_r[g], o_g[g], o_b[g], ox[g], oy[g]} !==
          {{2{!pol_of(g)}}, 3'b000, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0}) begin
        fails++;
        $display("FAIL async_reset inst%0d got hs=%b vs=%b bn=%b rd=%b r=%0h x=%0d y=%0d exp reset values",
                 g, hs[g], vs[g], bn[g], rd[g], o_r[g], ox[g], oy[g]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_stream(FR + 20, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) en[g] = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_frame();
    test_stall();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
